// File: rtl/systolic_pkg.sv
// Shared definitions for the PE systolic array edge logic.
// Holds the skew feeder FSM encoding, the lane width shared with the PE,
// and the helper that sizes the feeder's tile counter.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } feeder_state_t;

  // PE operand width; the feeder's default lane width follows it.
  localparam int PE_IN_LEN       = 8;
  localparam int FEEDER_MAX_TILE = 16;

  // Tile counter must be able to hold MAX_TILE itself (saturation value).
  function automatic int tile_cnt_w(input int max_tile);
    return $clog2(max_tile + 1);
  endfunction

endpackage

// File: rtl/skew_lane_delay.sv
// One lane of the skew feeder: a DEPTH-stage data+valid shift chain.
// The whole chain advances together when en is high and holds otherwise,
// so a global array stall freezes every stage including the output valid.
module skew_lane_delay #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid
);

  logic [DEPTH:1][DATA_W-1:0] dat_pipe;
  logic [DEPTH:1]             vld_pipe;

  // Stage 1 takes the head input; later stages take their predecessor.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dat_pipe <= '0;
      vld_pipe <= '0;
    end else if (en) begin
      dat_pipe[1] <= in_data;
      vld_pipe[1] <= in_valid;
      for (int s = 2; s <= DEPTH; s++) begin
        dat_pipe[s] <= dat_pipe[s-1];
        vld_pipe[s] <= vld_pipe[s-1];
      end
    end
  end

  assign out_data  = dat_pipe[DEPTH];
  assign out_valid = vld_pipe[DEPTH];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Upstream edge stage for the PE systolic array.
// Takes one N-lane vector per handshake and delays lane i by i extra cycles
// so the diagonal wavefront lands aligned on the edge PEs. After the last
// vector of a tile the heads are fed N-1 zero bubbles so every lane drains.
// Optional build macro SKEW_FEEDER_PERF_EN adds stall/bubble counters.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int N        = 4,
  parameter int DATA_W   = PE_IN_LEN,
  parameter int MAX_TILE = FEEDER_MAX_TILE
) (
  input  logic                clk,
  input  logic                sys_rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_data,
  input  logic                in_last,
  input  logic                out_ready,
  output logic                pe_en,
  output logic [N*DATA_W-1:0] out_data,
  output logic [N-1:0]        out_valid,
  output logic                tile_done,
  output logic                tile_overflow
`ifdef SKEW_FEEDER_PERF_EN
  ,
  input  logic                perf_clr,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         bubble_cnt
`endif
);

  localparam int TW = tile_cnt_w(MAX_TILE);
  localparam int FW = $clog2(N);

  feeder_state_t            state_q, state_d;
  logic [TW-1:0]            tile_cnt;
  logic [FW-1:0]            flush_cnt;
  logic                     adv, acc, flush_end;
  logic [N-1:0][DATA_W-1:0] head_data, lane_data;
  logic [N-1:0]             lane_valid;

  // Global advance: every chain shifts together or not at all.
  assign adv       = out_ready && (state_q != IDLE);
  // in_ready already implies adv, so this is the full acceptance condition.
  assign acc       = in_valid && in_ready;
  assign flush_end = adv && (state_q == FLUSH) && (flush_cnt == FW'(1));
  assign pe_en     = adv;

  // Next-state and ready decode; leaving IDLE needs no trigger.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE:   state_d = STREAM;
      STREAM: begin
        in_ready = out_ready;
        if (in_valid && out_ready && in_last) state_d = FLUSH;
      end
      FLUSH:  if (flush_end) state_d = STREAM;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset mid-tile drops the tile.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Tile length tracking, flush countdown and the tile_done pulse.
  // tile_done is registered so it lines up with lane N-1's last valid beat.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tile_cnt      <= '0;
      flush_cnt     <= '0;
      tile_overflow <= 1'b0;
      tile_done     <= 1'b0;
    end else begin
      tile_done <= flush_end;
      if (acc) begin
        if (in_last) begin
          tile_cnt  <= '0;
          flush_cnt <= FW'(N - 1);
        end else if (tile_cnt == TW'(MAX_TILE)) begin
          tile_overflow <= 1'b1;
        end else begin
          tile_cnt <= tile_cnt + TW'(1);
        end
      end else if (adv && (state_q == FLUSH) && (flush_cnt != '0)) begin
        flush_cnt <= flush_cnt - FW'(1);
      end
    end
  end

  // Lane i gets i+1 stages; non-accepted advances inject zero bubbles.
  for (genvar i = 0; i < N; i++) begin : g_lane
    assign head_data[i] = acc ? in_data[i*DATA_W +: DATA_W] : '0;

    skew_lane_delay #(
      .DEPTH  (i + 1),
      .DATA_W (DATA_W)
    ) u_lane (
      .clk       (clk),
      .sys_rst_n (sys_rst_n),
      .en        (adv),
      .in_data   (head_data[i]),
      .in_valid  (acc),
      .out_data  (lane_data[i]),
      .out_valid (lane_valid[i])
    );
  end

  assign out_data  = lane_data;
  assign out_valid = lane_valid;

`ifdef SKEW_FEEDER_PERF_EN
  // Saturating stall and bubble counters; perf_clr wins over counting.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (perf_clr) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if ((state_q != IDLE) && !out_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
      if ((state_q == STREAM) && adv && !acc && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder (N=4, DATA_W=8, MAX_TILE=16).
// A per-cycle vector table covers the basic tile, single-vector tile and a
// mid-tile stall; hand sequences cover overflow, reset in FLUSH and perf.
module tb_systolic_skew_feeder;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic        in_valid, in_last, out_ready;
  logic [31:0] in_data;
  logic        in_ready, pe_en, tile_done, tile_overflow;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
`ifdef SKEW_FEEDER_PERF_EN
  logic        perf_clr;
  logic [31:0] stall_cnt, bubble_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  systolic_skew_feeder #(.N(4), .DATA_W(8), .MAX_TILE(16)) dut (
    .clk           (clk),
    .sys_rst_n     (sys_rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .out_ready     (out_ready),
    .pe_en         (pe_en),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .tile_done     (tile_done),
    .tile_overflow (tile_overflow)
`ifdef SKEW_FEEDER_PERF_EN
    ,
    .perf_clr      (perf_clr),
    .stall_cnt     (stall_cnt),
    .bubble_cnt    (bubble_cnt)
`endif
  );

  typedef struct {
    logic        vld, last, ordy;
    logic [31:0] din;
    logic        e_rdy, e_pe;
    logic [3:0]  e_ov;
    logic [31:0] e_od;
    logic        e_td;
  } vec_t;

  vec_t tbl[27];

  function automatic vec_t mk(logic v, logic l, logic o, logic [31:0] d,
                              logic rdy, logic pe, logic [3:0] ov,
                              logic [31:0] od, logic td);
    vec_t r;
    r.vld = v; r.last = l; r.ordy = o; r.din = d;
    r.e_rdy = rdy; r.e_pe = pe; r.e_ov = ov; r.e_od = od; r.e_td = td;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " in_ready"},      32'(in_ready),      32'd0);
    chk({tag, " pe_en"},         32'(pe_en),         32'd0);
    chk({tag, " out_data"},      out_data,           32'd0);
    chk({tag, " out_valid"},     32'(out_valid),     32'd0);
    chk({tag, " tile_done"},     32'(tile_done),     32'd0);
    chk({tag, " tile_overflow"}, 32'(tile_overflow), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // V_k lane i = i + 0x10*k ; W_k lane i = 0xA0 + 0x10*i + k
    tbl[0]  = mk(0,0,1,32'h0,        0,0,4'b0000,32'h00000000,0); // IDLE
    tbl[1]  = mk(1,0,1,32'h03020100, 1,1,4'b0000,32'h00000000,0);
    tbl[2]  = mk(1,0,1,32'h13121110, 1,1,4'b0001,32'h00000000,0);
    tbl[3]  = mk(1,0,1,32'h23222120, 1,1,4'b0011,32'h00000110,0);
    tbl[4]  = mk(1,1,1,32'h33323130, 1,1,4'b0111,32'h00021120,0);
    tbl[5]  = mk(0,0,1,32'h0,        0,1,4'b1111,32'h03122130,0);
    tbl[6]  = mk(0,0,1,32'h0,        0,1,4'b1110,32'h13223100,0);
    tbl[7]  = mk(0,0,1,32'h0,        0,1,4'b1100,32'h23320000,0);
    tbl[8]  = mk(0,0,1,32'h0,        1,1,4'b1000,32'h33000000,1);
    tbl[9]  = mk(1,1,1,32'hAAAAAAAA, 1,1,4'b0000,32'h00000000,0);
    tbl[10] = mk(0,0,1,32'h0,        0,1,4'b0001,32'h000000AA,0);
    tbl[11] = mk(0,0,1,32'h0,        0,1,4'b0010,32'h0000AA00,0);
    tbl[12] = mk(0,0,1,32'h0,        0,1,4'b0100,32'h00AA0000,0);
    tbl[13] = mk(0,0,1,32'h0,        1,1,4'b1000,32'hAA000000,1);
    tbl[14] = mk(1,0,1,32'hD0C0B0A0, 1,1,4'b0000,32'h00000000,0);
    tbl[15] = mk(1,0,1,32'hD1C1B1A1, 1,1,4'b0001,32'h000000A0,0);
    for (int r = 16; r <= 20; r++)
      tbl[r] = mk(1,0,0,32'hD2C2B2A2, 0,0,4'b0011,32'h0000B0A1,0); // stall
    tbl[21] = mk(1,0,1,32'hD2C2B2A2, 1,1,4'b0011,32'h0000B0A1,0);
    tbl[22] = mk(1,1,1,32'hD3C3B3A3, 1,1,4'b0111,32'h00C0B1A2,0);
    tbl[23] = mk(0,0,1,32'h0,        0,1,4'b1111,32'hD0C1B2A3,0);
    tbl[24] = mk(0,0,1,32'h0,        0,1,4'b1110,32'hD1C2B300,0);
    tbl[25] = mk(0,0,1,32'h0,        0,1,4'b1100,32'hD2C30000,0);
    tbl[26] = mk(0,0,1,32'h0,        1,1,4'b1000,32'hD3000000,1);

    sys_rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1; in_data = '0;
`ifdef SKEW_FEEDER_PERF_EN
    perf_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1 chk_all_zero("reset");
    @(posedge clk); #2 sys_rst_n = 1'b1;

    // Table: one row per cycle, outputs sampled mid-low-phase.
    for (int r = 0; r < 27; r++) begin
      @(negedge clk);
      in_valid = tbl[r].vld; in_last = tbl[r].last;
      out_ready = tbl[r].ordy; in_data = tbl[r].din;
      #1;
      chk($sformatf("row%0d in_ready", r),  32'(in_ready),  32'(tbl[r].e_rdy));
      chk($sformatf("row%0d pe_en", r),     32'(pe_en),     32'(tbl[r].e_pe));
      chk($sformatf("row%0d out_valid", r), 32'(out_valid), 32'(tbl[r].e_ov));
      chk($sformatf("row%0d out_data", r),  out_data,       tbl[r].e_od);
      chk($sformatf("row%0d tile_done", r), 32'(tile_done), 32'(tbl[r].e_td));
    end

    // Overflow: 17 vectors, no in_last. Lane 0 shows vector k-1 at step k.
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_last = 1'b0; out_ready = 1'b1;
      in_data = {4{8'(8'h60 + k)}};
      #1;
      chk($sformatf("ovf%0d flag", k), 32'(tile_overflow), 32'd0);
      if (k > 0) begin
        chk($sformatf("ovf%0d lane0", k), {24'd0, out_data[7:0]}, 32'(8'h60 + k - 1));
        chk($sformatf("ovf%0d v0", k), 32'(out_valid[0]), 32'd1);
      end
    end
    @(negedge clk); in_valid = 1'b0; #1;
    chk("ovf rise", 32'(tile_overflow), 32'd1);
    chk("ovf 17th fwd", {24'd0, out_data[7:0]}, 32'h70);
    chk("ovf 17th v0", 32'(out_valid[0]), 32'd1);
    repeat (2) @(negedge clk);
    #1 chk("ovf sticky", 32'(tile_overflow), 32'd1);

    // Close the tile, then reset while in FLUSH.
    @(negedge clk); in_valid = 1'b1; in_last = 1'b1; in_data = 32'h5A5A5A5A;
    #1 chk("last accept rdy", 32'(in_ready), 32'd1);
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0; #1;
    chk("flush rdy", 32'(in_ready), 32'd0);
    chk("flush v0", 32'(out_valid[0]), 32'd1);
    chk("flush ovf sticky", 32'(tile_overflow), 32'd1);
    sys_rst_n = 1'b0;
    #1 chk_all_zero("async rst");
    @(posedge clk); @(posedge clk); #2 sys_rst_n = 1'b1;
    @(negedge clk); #1;
    chk("post-rst idle rdy", 32'(in_ready), 32'd0);
    chk("post-rst idle pe_en", 32'(pe_en), 32'd0);
    @(negedge clk); #1;
    chk("post-rst stream rdy", 32'(in_ready), 32'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      chk($sformatf("no stale valid %0d", c), 32'(out_valid), 32'd0);
      chk($sformatf("no stale done %0d", c), 32'(tile_done), 32'd0);
    end

`ifdef SKEW_FEEDER_PERF_EN
    @(negedge clk); perf_clr = 1'b1; in_valid = 1'b0;
    @(negedge clk); perf_clr = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk); out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h11111111;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0; #1;
    chk("perf stall_cnt", stall_cnt, 32'd3);
    chk("perf bubble_cnt", bubble_cnt, 32'd2);
    perf_clr = 1'b1;
    @(negedge clk); perf_clr = 1'b0; #1;
    chk("perf clr stall", stall_cnt, 32'd0);
    chk("perf clr bubble", bubble_cnt, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
